uart_tx_fifo: RTL and testbench

- UART transmitter; companion to the board's UART receiver on the same serial link.
- Accepts bytes over a valid/ready handshake into a small synchronous FIFO.
- Serialises bytes as 8N1 frames (LSB first, idle-high) at the configured baud rate.
- Sits between on-chip byte producers (echo path, key-driven message logic) and the uart_tx pin.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_tx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and default link constants.
// Used by both the transmit and receive paths so the two ends agree on line rate.
package uart_pkg;

   localparam int DEF_CLK_FREQ = 27_000_000;
   localparam int DEF_BAUD     = 115_200;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4
   } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, power-of-two DEPTH, head word visible on pop_dat.
// Latency: a pushed word is poppable on the next edge; simultaneous push/pop keeps count.
// Backpressure: push is ignored when full, pop is ignored when empty; no bypass.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign pop_dat = mem_q[rptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= push_dat;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, or 8E1 with UART_TX_PARITY_EN) fed by a byte FIFO.
// Latency: byte into empty FIFO while idle -> start bit on the next edge; back-to-back frames.
// Backpressure: tx_ready drops while the FIFO is full, independent of tx_valid and of pops.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = DEF_CLK_FREQ,
   parameter int BAUD       = DEF_BAUD,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          uart_tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int BAUD_CNT = CLK_FREQ / BAUD;
   localparam int CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT - 1);

   logic       fifo_pop, fifo_full, fifo_empty;
   logic [7:0] fifo_dat;

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             bit_end;
`ifdef UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (tx_valid && tx_ready),
      .push_dat (tx_data),
      .pop      (fifo_pop),
      .pop_dat  (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign tx_ready = !fifo_full;
   assign uart_tx  = tx_q;
   assign busy     = (state_q != ST_IDLE) || !fifo_empty;
   assign bit_end  = (baud_q == BAUD_LAST);

   always_comb begin
      state_d   = state_q;
      baud_d    = bit_end ? '0 : baud_q + CNT_W'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dat;
`ifdef UART_TX_PARITY_EN
               par_d    = ^fifo_dat;
`endif
               tx_d     = 1'b0;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               tx_d      = shift_q[0];
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = ST_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
`endif
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            // Chaining straight into the next start bit keeps bursts gap-free.
            if (bit_end) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dat;
`ifdef UART_TX_PARITY_EN
                  par_d    = ^fifo_dat;
`endif
                  tx_d     = 1'b0;
                  state_d  = ST_START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            baud_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at default parameters (234 clocks per bit).
// Frame shape follows UART_TX_PARITY_EN when the macro is defined for the build.
module tb_uart_tx_fifo;

   localparam int BIT_CYC = 234;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * BIT_CYC;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, uart_tx, busy;
   logic [2:0] fifo_count;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   uart_tx_fifo dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      int n;
      n = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < 20000) begin
         tick();
         n++;
      end
      check("push_ready_wait", 32'(tx_ready), 32'd1);
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic wait_fall(input string tag, output int n);
      n = 0;
      while (uart_tx !== 1'b0 && n < 3000) begin
         tick();
         n++;
      end
      check(tag, 32'(uart_tx), 32'd0);
   endtask

   // Walks one frame cycle by cycle from the first start-bit sample.
   task automatic check_frame(input logic [7:0] b, input string tag, output logic busy_end);
      int   bad;
      int   idx;
      logic e;
      bad      = 0;
      busy_end = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
         idx = c / BIT_CYC;
         if (idx == 0)                     e = 1'b0;
         else if (idx <= 8)                e = b[3'(idx - 1)];
         else if (idx == 9 && NBITS == 11) e = ^b;
         else                              e = 1'b1;
         if (uart_tx !== e) bad++;
         if (c == FRAME - 1) busy_end = busy;
         tick();
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   logic [7:0] burst [5];
   logic [7:0] coll  [4];
   int         n_main, n_mon;
   logic       be_main, be_mon;
   int         lows;

   initial begin
      burst[0] = 8'hA5; burst[1] = 8'h3C; burst[2] = 8'hFF; burst[3] = 8'h00; burst[4] = 8'h81;
      coll[0]  = 8'h11; coll[1]  = 8'h22; coll[2]  = 8'h33; coll[3]  = 8'h44;

      // Reset held with a valid byte on the input
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h12;
      ticks(3);
      check("rst_line", 32'(uart_tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      rst      = 1'b0;
      tx_valid = 1'b0;
      check("rst_ready", 32'(tx_ready), 32'd1);
      tick();
      check("rst_no_accept", 32'(fifo_count), 32'd0);
      check("rst_idle_busy", 32'(busy), 32'd0);

      // Single byte 0x55
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check("single_count", 32'(fifo_count), 32'd1);
      check("single_line_pre", 32'(uart_tx), 32'd1);
      check("single_busy", 32'(busy), 32'd1);
      wait_fall("single_fall", n_main);
      check("single_latency", 32'(n_main), 32'd1);
      check_frame(8'h55, "single_frame", be_main);
      check("single_busy_last", 32'(be_main), 32'd1);
      check("single_busy_drop", 32'(busy), 32'd0);
      check("single_line_idle", 32'(uart_tx), 32'd1);

      // Burst of five with tx_valid held
      fork
         begin
            for (int i = 0; i < 5; i++) push_byte(burst[i]);
            check("burst_full_count", 32'(fifo_count), 32'd4);
            check("burst_full_ready", 32'(tx_ready), 32'd0);
         end
         begin
            wait_fall("burst_fall", n_mon);
            for (int k = 0; k < 5; k++) check_frame(burst[k], "burst_frame", be_mon);
         end
      join
      check("burst_busy_end", 32'(busy), 32'd0);

      // Push coinciding with the STOP->START pop at count 2
      tick();
      fork
         begin
            push_byte(coll[0]);
            push_byte(coll[1]);
            push_byte(coll[2]);
            ticks(FRAME - 2);
            check("coll_pre_count", 32'(fifo_count), 32'd2);
            tx_data  = coll[3];
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            check("coll_post_count", 32'(fifo_count), 32'd2);
         end
         begin
            wait_fall("coll_fall", n_mon);
            for (int k = 0; k < 4; k++) check_frame(coll[k], "coll_frame", be_mon);
         end
      join

      // Reset at cycle 1000 of a frame with two bytes queued
      tick();
      push_byte(8'h00);
      push_byte(8'h5A);
      push_byte(8'hC3);
      check("mid_queued", 32'(fifo_count), 32'd2);
      ticks(998);
      check("mid_line_low", 32'(uart_tx), 32'd0);
      rst = 1'b1;
      tick();
      check("mid_rst_line", 32'(uart_tx), 32'd1);
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      rst  = 1'b0;
      lows = 0;
      for (int c = 0; c < 3000; c++) begin
         if (uart_tx !== 1'b1) lows++;
         tick();
      end
      check("mid_quiet", 32'(lows), 32'd0);
      check("mid_quiet_busy", 32'(busy), 32'd0);

      // Parity-sensitive bytes (odd and even popcount)
      push_byte(8'h07);
      wait_fall("par07_fall", n_main);
      check_frame(8'h07, "par07_frame", be_main);
      push_byte(8'h03);
      wait_fall("par03_fall", n_main);
      check_frame(8'h03, "par03_frame", be_main);
      check("par_busy_end", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
